// File: rtl/gf2m_mont_convert.sv
// Bit-serial GF(2^M) Montgomery-domain converter.
// dir=0 scales by x^M, dir=1 scales by x^-M, one bit step per clock.
module gf2m_mont_convert #(
  parameter int         M    = 3,
  parameter logic [M:0] POLY = 4'b1101
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_dir
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [M:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [M-1:0]    res_q, res_d;
  logic            rdir_q, rdir_d;

  logic [M:0]      fwd_v;
  logic [M:0]      rev_v;
  logic [M:0]      step_v;

  // One carry-free step: multiply by x or by x^-1, reducing by POLY.
  always_comb begin
    fwd_v = {acc_q[M-1:0], 1'b0};
    if (fwd_v[M]) begin
      fwd_v = fwd_v ^ POLY;
    end
    rev_v  = acc_q[0] ? (acc_q ^ POLY) : acc_q;
    rev_v  = rev_v >> 1;
    step_v = dir_q ? rev_v : fwd_v;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    res_d     = res_q;
    rdir_d    = rdir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = {1'b0, in_data};
          dir_d   = in_dir;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_v;
        cnt_d = cnt_q + 1'b1;
        // The M-th step lands straight in the result register.
        if (cnt_q == CW'(M - 1)) begin
          res_d   = step_v[M-1:0];
          rdir_d  = dir_q;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      res_q   <= '0;
      rdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      res_q   <= res_d;
      rdir_q  <= rdir_d;
    end
  end

  assign out_data = res_q;
  assign out_dir  = rdir_q;

endmodule

// File: tb/tb_gf2m_mont_convert.sv
// Scoreboard bench for gf2m_mont_convert against a
// polynomial-arithmetic reference model.
module tb_gf2m_mont_convert;

  localparam int M    = 3;
  localparam int POLY = 13;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] in_data = '0;
  logic         in_dir = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [M-1:0] out_data;
  logic         out_dir;

  gf2m_mont_convert #(.M(M), .POLY(4'b1101)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dir   (out_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] d;
    logic         dir;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b1;
  bit   rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // a * x^M reduced modulo POLY by long division.
  function automatic logic [M-1:0] fwd(input logic [M-1:0] a);
    int p;
    p = int'(a) << M;
    for (int k = 2 * M - 1; k >= M; k--) begin
      if (p[k]) p = p ^ (POLY << (k - M));
    end
    return p[M-1:0];
  endfunction

  // a * x^-M: the unique b with b * x^M == a.
  function automatic logic [M-1:0] rev(input logic [M-1:0] a);
    logic [M-1:0] r;
    r = '0;
    for (int b = 0; b < (1 << M); b++) begin
      if (fwd(M'(b)) == a) r = M'(b);
    end
    return r;
  endfunction

  // Monitor: a handshake completes at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {28'd0, out_dir, out_data}, 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_dir", out_dir, e.dir);
        if (chk_lat) chk("latency", cyc - e.cyc, M + 1);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [M-1:0] a, input logic d,
                      input logic [M-1:0] expv);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = a;
    in_dir   = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{d: expv, dir: d, cyc: cyc});
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [M-1:0] bb_d [4];
  logic         bb_r [4];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dir", out_dir, 0);

    send(3'b001, 1'b0, 3'b101);
    drain();
    send(3'b101, 1'b1, 3'b001);
    send(3'b111, 1'b1, 3'b010);
    send(3'b010, 1'b0, 3'b111);
    drain();

    for (int a = 0; a < 8; a++) begin
      send(M'(a), 1'b0, fwd(M'(a)));
      send(fwd(M'(a)), 1'b1, M'(a));
    end
    drain();

    // Backpressure: result must sit unchanged in DONE.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(3'b101, 1'b1, rev(3'b101));
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 3'b111;
        in_dir   = 1'b0;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, rev(3'b101));
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    chk_lat = 1'b1;
    send(3'b011, 1'b0, fwd(3'b011));
    drain();

    // Back-to-back with in_valid held high.
    bb_d[0] = 3'b110; bb_r[0] = 1'b0;
    bb_d[1] = 3'b011; bb_r[1] = 1'b1;
    bb_d[2] = 3'b100; bb_r[2] = 1'b1;
    bb_d[3] = 3'b001; bb_r[3] = 1'b0;
    begin
      int idx;
      int last;
      idx  = 0;
      last = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = bb_d[0];
      in_dir   = bb_r[0];
      for (int i = 0; i < 100 && idx < 4; i++) begin
        @(negedge clk);
        if (in_ready) begin
          exp_q.push_back('{d: bb_r[idx] ? rev(bb_d[idx]) : fwd(bb_d[idx]),
                            dir: bb_r[idx], cyc: cyc});
          if (idx > 0) chk("spacing", cyc - last, M + 2);
          last = cyc;
          idx++;
          @(posedge clk); #1;
          if (idx < 4) begin
            in_data = bb_d[idx];
            in_dir  = bb_r[idx];
          end
        end
      end
      in_valid = 1'b0;
      if (idx != 4) chk("bb_accepts", idx, 4);
    end
    drain();

    // Reset in the middle of a conversion.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 3'b011;
    in_dir   = 1'b1;
    @(negedge clk);
    chk("mr_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_out_dir", out_dir, 0);
    repeat (8) @(posedge clk);
    send(3'b001, 1'b0, 3'b101);
    drain();

    // Random requests under random backpressure.
    chk_lat   = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [M-1:0] a;
      logic         d;
      a = M'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      send(a, d, d ? rev(a) : fwd(a));
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
